ext_mem_arbiter: RTL

- Shares one external memory port between two requesters:
  - the core's ext_* memory interface (requester C);
  - the Wishbone slave port from the management SoC (requester W).
- Sits between the core/Wishbone wiring in the user project wrapper and the memory macro or controller.
- Round-robin arbitration, one outstanding transaction, request capture and a watchdog timeout that returns an error so neither master can hang.

---
 rtl/ext_mem_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/ext_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the core ext_* bus (C)
// and the Wishbone slave (W). One transaction in flight; a watchdog errors out stalled accesses.
module ext_mem_arbiter #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ext_valid,
    input  logic              ext_instruction,
    input  logic [ADDR_W-1:0] ext_address,
    input  logic [31:0]       ext_write_data,
    input  logic [3:0]        ext_write_strobe,
    output logic              ext_ready,
    output logic [31:0]       ext_read_data,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [ADDR_W-1:0] wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    output logic              mem_valid,
    output logic              mem_we,
    output logic              mem_fetch,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata,
    output logic              timeout_err
);

    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t           state;
    logic             last_w;   // 1 when the most recent grant went to W
    logic             owner_w;  // requester of the transaction in flight
    logic [CNT_W-1:0] wd_cnt;
    logic             req_c;
    logic             req_w;
    logic             pick_w;
    logic             wd_expire;
    logic [31:0]      resp_data;

    assign req_c  = ext_valid;
    assign req_w  = wbs_cyc_i & wbs_stb_i;
    assign pick_w = req_w & (~req_c | ~last_w);

    // Expires on the TIMEOUT-th ISSUE cycle without mem_ready; a same-cycle ready wins.
    assign wd_expire = (TIMEOUT != 0) && (wd_cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        resp_data = ERR_DATA;
        if (mem_ready) begin
            resp_data = mem_we ? 32'h0 : mem_rdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            last_w        <= 1'b1;
            owner_w       <= 1'b0;
            wd_cnt        <= '0;
            ext_ready     <= 1'b0;
            ext_read_data <= 32'h0;
            wbs_ack_o     <= 1'b0;
            wbs_dat_o     <= 32'h0;
            mem_valid     <= 1'b0;
            mem_we        <= 1'b0;
            mem_fetch     <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= 32'h0;
            mem_wstrb     <= 4'h0;
            timeout_err   <= 1'b0;
        end else begin
            ext_ready   <= 1'b0;
            wbs_ack_o   <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_c | req_w) begin
                        owner_w   <= pick_w;
                        last_w    <= pick_w;
                        wd_cnt    <= '0;
                        mem_valid <= 1'b1;
                        state     <= ISSUE;
                        if (pick_w) begin
                            mem_we    <= wbs_we_i;
                            mem_wstrb <= wbs_we_i ? wbs_sel_i : 4'h0;
                            mem_fetch <= 1'b0;
                            mem_addr  <= wbs_adr_i;
                            mem_wdata <= wbs_dat_i;
                        end else begin
                            mem_we    <= |ext_write_strobe;
                            mem_wstrb <= ext_write_strobe;
                            mem_fetch <= ext_instruction;
                            mem_addr  <= ext_address;
                            mem_wdata <= ext_write_data;
                        end
                    end
                end
                ISSUE: begin
                    if (mem_ready || wd_expire) begin
                        mem_valid   <= 1'b0;
                        timeout_err <= ~mem_ready;
                        state       <= RESP;
                        // Pulse only if the owner is still requesting; the access completes regardless.
                        if (owner_w) begin
                            wbs_dat_o <= resp_data;
                            wbs_ack_o <= req_w;
                        end else begin
                            ext_read_data <= resp_data;
                            ext_ready     <= req_c;
                        end
                    end else begin
                        wd_cnt <= wd_cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    wd_cnt <= '0;
                    state  <= IDLE;
                end
                default: begin
                    mem_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
